// File: rtl/pmod_enc_decoder.sv
// Pmod ENC front-end: syncs and debounces raw A/B/button/switch pins, then decodes detent steps into a wrap-around count.
// Latency: raw pin edge to debounced level is 2 + DEBOUNCE_CYCLES cycles; debounced final AB=11 to enc update is 1 cycle.
// No backpressure: outputs are registered levels plus a single-cycle step pulse for the display stage.
// Ports: clk, rst (async active-high); a, b, btn, swt raw pins; enc count, sw switch level, dir last-step direction, step pulse.
module pmod_enc_decoder #(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int MAX_COUNT       = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       btn,
    input  logic       swt,
    output logic [4:0] enc,
    output logic       sw,
    output logic       dir,
    output logic       step
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] MAX_ENC = 5'(MAX_COUNT);

    // Bit order of the per-input vectors: 0 = b, 1 = a, 2 = btn, 3 = swt.
    // A/B idle high at a detent, so they come out of reset high to avoid a
    // spurious transition into the quadrature decoder.
    localparam logic [3:0] RST_LVL = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        CW1,
        CW2,
        CW3,
        CCW1,
        CCW2,
        CCW3
    } state_t;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [CNT_W-1:0] db_cnt [4];

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ab;
    logic       inc;
    logic       dec;
    logic       btn_prev;
    logic       btn_rise;

    assign raw = {swt, btn, a, b};

    // Two-flop synchronisers followed by a per-input stability counter. The
    // counter only runs while the synced level disagrees with the debounced
    // one, so any disagreement shorter than DEBOUNCE_CYCLES is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RST_LVL;
            sync2 <= RST_LVL;
            deb   <= RST_LVL;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ab = {deb[1], deb[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each direction must walk all four Gray phases before returning to 11.
    // Stepping back one phase is followed; an impossible two-bit jump is
    // ignored, except that reaching 11 early always abandons the step.
    always_comb begin
        state_nxt = state;
        inc       = 1'b0;
        dec       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ab == 2'b01)      state_nxt = CW1;
                else if (ab == 2'b10) state_nxt = CCW1;
            end
            CW1: begin
                if (ab == 2'b00)      state_nxt = CW2;
                else if (ab == 2'b11) state_nxt = IDLE;
            end
            CW2: begin
                if (ab == 2'b10)      state_nxt = CW3;
                else if (ab == 2'b01) state_nxt = CW1;
                else if (ab == 2'b11) state_nxt = IDLE;
            end
            CW3: begin
                if (ab == 2'b11) begin
                    state_nxt = IDLE;
                    inc       = 1'b1;
                end else if (ab == 2'b00) begin
                    state_nxt = CW2;
                end
            end
            CCW1: begin
                if (ab == 2'b00)      state_nxt = CCW2;
                else if (ab == 2'b11) state_nxt = IDLE;
            end
            CCW2: begin
                if (ab == 2'b01)      state_nxt = CCW3;
                else if (ab == 2'b10) state_nxt = CCW1;
                else if (ab == 2'b11) state_nxt = IDLE;
            end
            CCW3: begin
                if (ab == 2'b11) begin
                    state_nxt = IDLE;
                    dec       = 1'b1;
                end else if (ab == 2'b00) begin
                    state_nxt = CCW2;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign btn_rise = deb[2] & ~btn_prev;

    // Button clear takes priority over a step completing in the same cycle:
    // the count goes to zero, direction is left alone, and only one pulse
    // is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= 1'b0;
            enc      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
        end else begin
            btn_prev <= deb[2];
            step     <= 1'b0;
            if (btn_rise) begin
                enc  <= '0;
                step <= 1'b1;
            end else if (inc) begin
                enc  <= (enc == MAX_ENC) ? 5'd0 : enc + 5'd1;
                dir  <= 1'b1;
                step <= 1'b1;
            end else if (dec) begin
                enc  <= (enc == 5'd0) ? MAX_ENC : enc - 5'd1;
                dir  <= 1'b0;
                step <= 1'b1;
            end
        end
    end

    // The debounced switch level is already a flop; it feeds the display as-is.
    assign sw = deb[3];

endmodule

// File: tb/tb_pmod_enc_decoder.sv
// Bench for pmod_enc_decoder: directed scenarios followed by randomized detent/glitch/button/switch events.
// Expected count, direction, pulse total and switch level come from a phase-displacement model of the encoder.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point or on the falling edge.
module tb_pmod_enc_decoder;

    localparam int DB   = 16;
    localparam int MAXC = 19;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b1;
    logic       b   = 1'b1;
    logic       btn = 1'b0;
    logic       swt = 1'b0;
    logic [4:0] enc;
    logic       sw;
    logic       dir;
    logic       step;

    pmod_enc_decoder #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_COUNT      (MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .btn (btn),
        .swt (swt),
        .enc (enc),
        .sw  (sw),
        .dir (dir),
        .step(step)
    );

    always #5 clk = ~clk;

    int errors     = 0;
    int checks     = 0;
    int step_seen  = 0;

    always @(negedge clk) begin
        if (step === 1'b1) step_seen++;
    end

    // Reference model: position on the Gray cycle (11,01,00,10 = phase 0..3
    // clockwise) and signed displacement away from the detent.
    int         m_enc   = 0;
    int         m_dir   = 0;
    int         m_steps = 0;
    int         m_phase = 0;
    int         m_disp  = 0;
    int         m_sw    = 0;
    logic [1:0] cur_ab  = 2'b11;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_sym(input logic [1:0] ab);
        int p;
        int d;
        p = phase_of(ab);
        d = (p - m_phase + 4) % 4;
        if (p == 0) begin
            if (m_disp == 3) begin
                m_enc = (m_enc + 1) % (MAXC + 1);
                m_dir = 1;
                m_steps++;
            end else if (m_disp == -3) begin
                m_enc = (m_enc + MAXC) % (MAXC + 1);
                m_dir = 0;
                m_steps++;
            end
            m_disp  = 0;
            m_phase = 0;
        end else if (d == 1) begin
            m_disp++;
            m_phase = p;
        end else if (d == 3) begin
            m_disp--;
            m_phase = p;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic check_all(input string tag);
        check({tag, ".enc"},  int'(enc), m_enc);
        check({tag, ".dir"},  int'(dir), m_dir);
        check({tag, ".step"}, step_seen, m_steps);
    endtask

    task automatic drive_sym(input logic [1:0] ab);
        a      = ab[1];
        b      = ab[0];
        cur_ab = ab;
        hold(2 * DB);
        model_sym(ab);
    endtask

    task automatic detent_cw();
        drive_sym(2'b01);
        drive_sym(2'b00);
        drive_sym(2'b10);
        drive_sym(2'b11);
    endtask

    task automatic detent_ccw();
        drive_sym(2'b10);
        drive_sym(2'b00);
        drive_sym(2'b01);
        drive_sym(2'b11);
    endtask

    task automatic press(input int n);
        btn = 1'b1;
        hold(n);
        btn = 1'b0;
        hold(2 * DB);
        m_enc = 0;
        m_steps++;
    endtask

    task automatic set_enc(input int v);
        press(40);
        repeat (v) detent_cw();
    endtask

    initial begin
        // Reset state
        hold(3);
        check("rst.enc",  int'(enc),  0);
        check("rst.sw",   int'(sw),   0);
        check("rst.dir",  int'(dir),  0);
        check("rst.step", int'(step), 0);
        rst = 1'b0;
        hold(4);

        // One clockwise detent
        detent_cw();
        check_all("cw1");

        // Counter-clockwise wraps 0 -> MAX, then clockwise all the way round
        press(40);
        check_all("clr");
        detent_ccw();
        check_all("ccw_wrap");
        for (int i = 0; i < MAXC; i++) begin
            detent_cw();
            check_all("cw_walk");
        end
        detent_cw();
        check_all("cw_to_max");
        detent_cw();
        check_all("cw_wrap0");

        // Short glitches on A at the detent are swallowed
        set_enc(3);
        for (int i = 0; i < 4; i++) begin
            a = 1'b0;
            hold(5);
            a = 1'b1;
            hold(DB + 7);
        end
        check_all("glitch");

        // Reversal before completing the detent
        set_enc(7);
        drive_sym(2'b01);
        drive_sym(2'b00);
        drive_sym(2'b01);
        drive_sym(2'b11);
        check_all("reverse");

        // Button clear, then long hold gives no further pulses
        set_enc(12);
        btn = 1'b1;
        hold(40);
        m_enc = 0;
        m_steps++;
        check_all("btn_press");
        hold(200);
        check_all("btn_hold");
        btn = 1'b0;
        hold(2 * DB);
        check_all("btn_release");

        // Detent completion and button edge in the same cycle
        set_enc(5);
        drive_sym(2'b01);
        drive_sym(2'b00);
        drive_sym(2'b10);
        m_dir = int'(dir);
        b   = 1'b1;
        btn = 1'b1;
        cur_ab = 2'b11;
        hold(40);
        btn = 1'b0;
        hold(2 * DB);
        m_phase = 0;
        m_disp  = 0;
        m_enc   = 0;
        m_dir   = 1;
        m_steps++;
        check_all("collide");

        // Reset in the middle of a rotation
        set_enc(4);
        drive_sym(2'b01);
        drive_sym(2'b00);
        rst = 1'b1;
        hold(3);
        a = 1'b1;
        b = 1'b1;
        cur_ab = 2'b11;
        rst = 1'b0;
        m_enc = 0; m_dir = 0; m_phase = 0; m_disp = 0;
        hold(2 * DB);
        check_all("mid_rst");
        detent_cw();
        check_all("post_rst_cw");

        // Switch latency is 2 + DEBOUNCE_CYCLES
        swt = 1'b1;
        hold(DB + 1);
        check("sw_early", int'(sw), 0);
        tick();
        check("sw_latency", int'(sw), 1);
        m_sw = 1;
        hold(4);

        // Randomized events
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                int np;
                np = (phase_of(cur_ab) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
                drive_sym(ab_of(np));
            end else if (r == 6) begin
                drive_sym(ab_of($urandom_range(0, 3)));
            end else if (r == 7) begin
                int len;
                len = $urandom_range(1, DB - 2);
                if ($urandom_range(0, 1) == 1) a = ~a; else b = ~b;
                hold(len);
                a = cur_ab[1];
                b = cur_ab[0];
                hold(2 * DB);
            end else if (r == 8) begin
                press($urandom_range(DB + 4, 3 * DB));
            end else begin
                swt  = ~swt;
                m_sw = int'(swt);
                hold(2 * DB);
            end
            check_all("rand");
            check("rand.sw", int'(sw), m_sw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
